// File: rtl/mul_unit_pkg.sv
// Shared pipeline types for the RV64M multiply unit: opcode and FSM state
// encodings, core timing, and the signed-magnitude helper.
package mul_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_MULW   = 3'd4
  } mul_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_BUSY  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } mul_state_t;

  // Cycles from the core's load edge until its done pulse is visible.
  localparam int unsigned CORE_LATENCY = 64;

  // Two's-complement magnitude; 0x8000_0000_0000_0000 maps to 2^63 unsigned.
  function automatic logic [63:0] abs64(input logic [63:0] x);
    abs64 = x[63] ? (~x + 64'd1) : x;
  endfunction

endpackage

// File: rtl/mul_unit_multiplier_64.sv
// Unsigned 64x64->128 shift-add multiplier, one partial product per cycle.
// Fixed latency regardless of operand values; done is a one-cycle pulse.
module multiplier_64
  import mul_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic         done,
  output logic [127:0] product
);

  logic [127:0] acc_r;
  logic [127:0] mcand_r;
  logic [63:0]  mplier_r;
  logic [6:0]   cnt_r;
  logic         busy_r;
  logic         done_r;

  // Load on valid when idle, then accumulate one multiplier bit per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r    <= 128'd0;
      mcand_r  <= 128'd0;
      mplier_r <= 64'd0;
      cnt_r    <= 7'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (busy_r) begin
        if (mplier_r[0]) begin
          acc_r <= acc_r + mcand_r;
        end
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
        cnt_r    <= cnt_r + 7'd1;
        if (cnt_r == 7'(CORE_LATENCY - 1)) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
      end else if (valid) begin
        acc_r    <= 128'd0;
        mcand_r  <= {64'd0, a};
        mplier_r <= b;
        cnt_r    <= 7'd0;
        busy_r   <= 1'b1;
      end
    end
  end

  assign done    = done_r;
  assign product = acc_r;

endmodule

// File: rtl/mul_unit.sv
// RV64M multiply unit: sign handling and handshake FSM wrapped around the
// unsigned iterative core. Accept-to-out_valid is CORE_LATENCY + 2 cycles.
module mul_unit
  import mul_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  mul_op_t     op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result
);

  mul_state_t   state_r;
  mul_state_t   state_s;
  mul_op_t      op_r;
  logic [63:0]  mag_a_r;
  logic [63:0]  mag_b_r;
  logic         neg_r;
  logic         armed_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic [63:0]  result_r;

  logic [63:0]  mag_a_s;
  logic [63:0]  mag_b_s;
  logic         neg_s;
  logic         core_valid_s;
  logic         core_done_s;
  logic [127:0] core_product_s;
  logic [127:0] signed_product_s;
  logic [63:0]  result_s;

  // Operand magnitudes and result sign for the incoming request.
  always_comb begin
    mag_a_s = a;
    mag_b_s = b;
    neg_s   = 1'b0;
    case (op)
      OP_MUL, OP_MULH: begin
        mag_a_s = abs64(a);
        mag_b_s = abs64(b);
        neg_s   = a[63] ^ b[63];
      end
      OP_MULHSU: begin
        mag_a_s = abs64(a);
        mag_b_s = b;
        neg_s   = a[63];
      end
      OP_MULHU: begin
        mag_a_s = a;
        mag_b_s = b;
        neg_s   = 1'b0;
      end
      OP_MULW: begin
        mag_a_s = {32'd0, a[31:0]};
        mag_b_s = {32'd0, b[31:0]};
        neg_s   = 1'b0;
      end
      default: begin
        mag_a_s = a;
        mag_b_s = b;
        neg_s   = 1'b0;
      end
    endcase
  end

  assign core_valid_s = (state_r == ST_LOAD);

  multiplier_64 u_core (
    .clk     (clk),
    .reset   (reset),
    .valid   (core_valid_s),
    .a       (mag_a_r),
    .b       (mag_b_r),
    .done    (core_done_s),
    .product (core_product_s)
  );

  // Re-apply the sign to the core product and pick the architectural slice.
  always_comb begin
    signed_product_s = neg_r ? (~core_product_s + 128'd1) : core_product_s;
    case (op_r)
      OP_MUL:                       result_s = signed_product_s[63:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_s = signed_product_s[127:64];
      OP_MULW:                      result_s = {{32{signed_product_s[31]}}, signed_product_s[31:0]};
      default:                      result_s = signed_product_s[63:0];
    endcase
  end

  // Next-state logic; a flushed request still lets the core finish in DRAIN.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && !flush) state_s = ST_LOAD;
        else                    state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (flush) state_s = ST_DRAIN;
        else       state_s = ST_BUSY;
      end
      ST_BUSY: begin
        // done arriving with flush means nothing is left to drain
        if (flush) begin
          if (armed_r && core_done_s) state_s = ST_IDLE;
          else                        state_s = ST_DRAIN;
        end else if (armed_r && core_done_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (flush || out_ready) state_s = ST_IDLE;
        else                    state_s = ST_DONE;
      end
      ST_DRAIN: begin
        if (core_done_s) state_s = ST_IDLE;
        else             state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, captured request and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_MUL;
      mag_a_r     <= 64'd0;
      mag_b_r     <= 64'd0;
      neg_r       <= 1'b0;
      armed_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= 64'd0;
    end else begin
      state_r     <= state_s;
      armed_r     <= (state_r == ST_BUSY);
      in_ready_r  <= (state_s == ST_IDLE);
      out_valid_r <= (state_s == ST_DONE);
      if (state_r == ST_IDLE && state_s == ST_LOAD) begin
        op_r    <= op;
        mag_a_r <= mag_a_s;
        mag_b_r <= mag_b_s;
        neg_r   <= neg_s;
      end
      if (state_r == ST_BUSY && state_s == ST_DONE) begin
        result_r <= result_s;
      end else if (state_s != ST_DONE) begin
        result_r <= 64'd0;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed RV64M corner cases, randomized
// operations against an arithmetic reference, flush/reset/backpressure scenarios.
module tb_mul_unit;
  import mul_unit_pkg::*;

  localparam int LAT = 66;   // 64-cycle core plus load and result capture

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  mul_op_t     op;
  logic [63:0] a;
  logic [63:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;

  int n_checks;
  int n_fail;

  mul_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact 128-bit product of the suitably extended operands.
  function automatic logic [63:0] ref_mul(input mul_op_t o, input logic [63:0] x, input logic [63:0] y);
    logic [127:0] xe;
    logic [127:0] ye;
    logic [127:0] p;
    xe = {64'd0, x};
    ye = {64'd0, y};
    if (o == OP_MUL || o == OP_MULH || o == OP_MULHSU) xe = {{64{x[63]}}, x};
    if (o == OP_MUL || o == OP_MULH) ye = {{64{y[63]}}, y};
    if (o == OP_MULW) begin
      xe = {96'd0, x[31:0]};
      ye = {96'd0, y[31:0]};
    end
    p = xe * ye;
    case (o)
      OP_MUL:  return p[63:0];
      OP_MULW: return {{32{p[31]}}, p[31:0]};
      default: return p[127:64];
    endcase
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one request from IDLE and wait for out_valid; leaves out_valid pending.
  task automatic run_op(input mul_op_t o, input logic [63:0] x, input logic [63:0] y,
                        output logic [63:0] res, output int lat,
                        output bit busy_ok, output bit zero_ok);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0; busy_ok = 1'b1; zero_ok = 1'b1;
    while (!out_valid && lat < 300) begin
      if (in_ready) busy_ok = 1'b0;
      if (result !== 64'd0) zero_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL reset_result got %h exp 0", result); end
  endtask

  task automatic test_directed();
    mul_op_t     d_op [7];
    logic [63:0] d_a [7];
    logic [63:0] d_b [7];
    logic [63:0] d_exp [7];
    logic [63:0] res;
    int lat;
    bit busy_ok, zero_ok;
    d_op[0] = OP_MUL;    d_a[0] = 64'd3;                  d_b[0] = 64'd5;                  d_exp[0] = 64'd15;
    d_op[1] = OP_MULH;   d_a[1] = 64'hFFFF_FFFF_FFFF_FFFF; d_b[1] = 64'hFFFF_FFFF_FFFF_FFFF; d_exp[1] = 64'd0;
    d_op[2] = OP_MULHSU; d_a[2] = 64'hFFFF_FFFF_FFFF_FFFF; d_b[2] = 64'hFFFF_FFFF_FFFF_FFFF; d_exp[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    d_op[3] = OP_MULHU;  d_a[3] = 64'hFFFF_FFFF_FFFF_FFFF; d_b[3] = 64'hFFFF_FFFF_FFFF_FFFF; d_exp[3] = 64'hFFFF_FFFF_FFFF_FFFE;
    d_op[4] = OP_MULH;   d_a[4] = 64'h8000_0000_0000_0000; d_b[4] = 64'h8000_0000_0000_0000; d_exp[4] = 64'h4000_0000_0000_0000;
    d_op[5] = OP_MUL;    d_a[5] = 64'h8000_0000_0000_0000; d_b[5] = 64'h8000_0000_0000_0000; d_exp[5] = 64'd0;
    d_op[6] = OP_MULW;   d_a[6] = 64'h7FFF_FFFF;           d_b[6] = 64'd2;                  d_exp[6] = 64'hFFFF_FFFF_FFFF_FFFE;
    for (int i = 0; i < 7; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], res, lat, busy_ok, zero_ok);
      n_checks++; if (res !== d_exp[i]) begin n_fail++; $display("FAIL dir_result[%0d] got %h exp %h", i, res, d_exp[i]); end
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL dir_latency[%0d] got %0d exp %0d", i, lat, LAT); end
      n_checks++; if (!busy_ok) begin n_fail++; $display("FAIL dir_in_ready_busy[%0d] got 1 exp 0", i); end
      n_checks++; if (!zero_ok) begin n_fail++; $display("FAIL dir_result_zero[%0d] got nonzero exp 0", i); end
      release_out();
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL dir_release[%0d] got out_valid=%b in_ready=%b exp 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    mul_op_t o;
    logic [63:0] x, y, res, exp_v;
    int lat;
    bit busy_ok, zero_ok;
    for (int i = 0; i < 30; i++) begin
      o = mul_op_t'($urandom_range(0, 4));
      x = pick_operand();
      y = pick_operand();
      exp_v = ref_mul(o, x, y);
      run_op(o, x, y, res, lat, busy_ok, zero_ok);
      n_checks++; if (res !== exp_v) begin n_fail++; $display("FAIL rand_result op=%0d a=%h b=%h got %h exp %h", o, x, y, res, exp_v); end
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rand_latency got %0d exp %0d", lat, LAT); end
      n_checks++; if (!busy_ok || !zero_ok) begin n_fail++; $display("FAIL rand_busy got busy_ok=%b zero_ok=%b exp 1/1", busy_ok, zero_ok); end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] x, y, res, exp_v;
    int lat;
    bit busy_ok, zero_ok;
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    exp_v = ref_mul(OP_MULHU, x, y);
    run_op(OP_MULHU, x, y, res, lat, busy_ok, zero_ok);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || result !== exp_v) begin
        n_fail++; $display("FAIL bp_hold[%0d] got valid=%b result=%h exp 1/%h", i, out_valid, result, exp_v);
      end
    end
    release_out();
  endtask

  task automatic test_flush_inflight(input int flush_at, input string tag);
    int idx;
    bit saw_valid;
    logic [63:0] res;
    int lat;
    bit busy_ok, zero_ok;
    @(negedge clk);
    op = OP_MUL; a = 64'd123; b = 64'd456; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (flush_at - 1) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idx = flush_at;
    saw_valid = 1'b0;
    while (!in_ready && idx < 300) begin
      if (out_valid) saw_valid = 1'b1;
      @(negedge clk);
      idx++;
    end
    n_checks++; if (saw_valid || out_valid) begin n_fail++; $display("FAIL %s_no_valid got 1 exp 0", tag); end
    n_checks++; if (idx != LAT) begin n_fail++; $display("FAIL %s_ready_return got %0d exp %0d", tag, idx, LAT); end
    run_op(OP_MUL, 64'd7, 64'd6, res, lat, busy_ok, zero_ok);
    n_checks++; if (res !== 64'd42) begin n_fail++; $display("FAIL %s_next_result got %h exp 42", tag, res); end
    release_out();
  endtask

  task automatic test_flush_done();
    logic [63:0] res;
    int lat;
    bit busy_ok, zero_ok;
    run_op(OP_MUL, 64'd9, 64'd9, res, lat, busy_ok, zero_ok);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || result !== 64'd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_done got valid=%b result=%h ready=%b exp 0/0/1", out_valid, result, in_ready);
    end
  endtask

  task automatic test_flush_idle();
    bit saw_valid;
    @(negedge clk);
    op = OP_MUL; a = 64'd2; b = 64'd2; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_ready got %b exp 1", in_ready); end
    saw_valid = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    n_checks++; if (saw_valid) begin n_fail++; $display("FAIL flush_idle_valid got 1 exp 0"); end
  endtask

  task automatic test_reset_mid_busy();
    logic [63:0] res;
    int lat;
    bit busy_ok, zero_ok;
    @(negedge clk);
    op = OP_MULH; a = 64'hDEAD_BEEF_0000_0001; b = 64'h1234_5678_9ABC_DEF0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 64'd0) begin
      n_fail++; $display("FAIL reset_busy got valid=%b ready=%b result=%h exp 0/1/0", out_valid, in_ready, result);
    end
    run_op(OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, res, lat, busy_ok, zero_ok);
    n_checks++; if (res !== ref_mul(OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3)) begin
      n_fail++; $display("FAIL reset_busy_next got %h exp %h", res, ref_mul(OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3));
    end
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL reset_busy_latency got %0d exp %0d", lat, LAT); end
    release_out();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; in_valid = 1'b0; op = OP_MUL; a = 64'd0; b = 64'd0;
    flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush_inflight(10, "flush_busy");
    test_flush_inflight(1, "flush_load");
    test_flush_done();
    test_flush_idle();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

endmodule
